// File: rtl/adxl355_pkg.sv
// Shared constants and types for the ADXL355-style SPI register slave:
// register map, reset values, identification bytes and the transaction FSM type.
package adxl355_pkg;

  localparam logic [6:0] ADDR_DEVID_AD  = 7'h00;
  localparam logic [6:0] ADDR_DEVID_MST = 7'h01;
  localparam logic [6:0] ADDR_PARTID    = 7'h02;
  localparam logic [6:0] ADDR_XDATA3    = 7'h08;
  localparam logic [6:0] ADDR_XDATA2    = 7'h09;
  localparam logic [6:0] ADDR_XDATA1    = 7'h0A;
  localparam logic [6:0] ADDR_YDATA3    = 7'h0B;
  localparam logic [6:0] ADDR_YDATA2    = 7'h0C;
  localparam logic [6:0] ADDR_YDATA1    = 7'h0D;
  localparam logic [6:0] ADDR_ZDATA3    = 7'h0E;
  localparam logic [6:0] ADDR_ZDATA2    = 7'h0F;
  localparam logic [6:0] ADDR_ZDATA1    = 7'h10;
  localparam logic [6:0] ADDR_FILTER    = 7'h28;
  localparam logic [6:0] ADDR_POWER_CTL = 7'h2D;

  localparam logic [7:0] DEVID_AD_DEFAULT = 8'hAD;
  localparam logic [7:0] DEVID_MST        = 8'h1D;
  localparam logic [7:0] PARTID           = 8'hED;

  localparam logic [7:0] POWER_CTL_RST = 8'h01;
  localparam logic [7:0] FILTER_RST    = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [19:0] x;
    logic [19:0] y;
    logic [19:0] z;
  } sample_t;

  // Burst address auto-increment; 7-bit arithmetic wraps 0x7F to 0x00.
  function automatic logic [6:0] next_addr(input logic [6:0] a);
    return a + 7'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived in the clk domain from the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(din);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adxl355_spi_slave.sv
// SPI mode-0 register slave modelled on the ADXL355: command byte {addr, rnw},
// auto-incrementing burst reads/writes, and coherent XYZ sample shadowing.
module adxl355_spi_slave
  import adxl355_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_AD    = DEVID_AD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        rx,
  output logic        tx,
  input  logic [19:0] xdata_in,
  input  logic [19:0] ydata_in,
  input  logic [19:0] zdata_in,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data,
  output state_t      fsm_state
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic rx_lvl, rx_rise, rx_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rx (
    .clk(clk), .rst(rst), .din(rx),
    .level(rx_lvl), .rise(rx_rise), .fall(rx_fall)
  );

  // rx only needs its level; sclk only needs its edges.
  logic unused_sync;
  assign unused_sync = &{1'b0, rx_rise, rx_fall, sclk_lvl};

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_shift_q;
  logic [7:0]  tx_shift_q;
  logic [6:0]  addr_q;
  logic        rnw_q;
  sample_t     shadow_q, pend_q, sample_in;
  logic        pend_valid_q;

  logic        cmd_done, byte_done, wr_fire, load_en;
  logic        tx_hold, tx_shift_en;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_byte;

  assign fsm_state = state_q;
  assign sample_in = '{x: xdata_in, y: ydata_in, z: zdata_in};

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: a synchronized-high cs_n always wins and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (cs_lvl)        state_d = ST_IDLE;
        else if (cmd_done) state_d = ST_DATA;
      end
      ST_DATA: if (cs_lvl) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: per-cycle control strobes for the datapath.
  always_comb begin
    cmd_done    = 1'b0;
    byte_done   = 1'b0;
    tx_hold     = 1'b0;
    tx_shift_en = 1'b0;
    case (state_q)
      ST_CMD: cmd_done = sclk_rise && (bit_cnt_q == 3'd7) && !cs_lvl;
      ST_DATA: begin
        // Not gated by cs_n: a byte finishing with cs_n rising still completes.
        byte_done   = sclk_rise && (bit_cnt_q == 3'd7);
        tx_hold     = rnw_q && !cs_lvl;
        tx_shift_en = rnw_q && !cs_lvl && sclk_fall;
      end
      default: ;
    endcase
  end

  assign wr_fire = byte_done && !rnw_q;
  assign load_en = (cmd_done && rx_lvl) || (byte_done && rnw_q);
  assign rd_addr = cmd_done ? rx_shift_q : next_addr(addr_q);

  // Bit counter, receive shift register, address and direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      addr_q     <= '0;
      rnw_q      <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (cs_fall) bit_cnt_q <= '0;
    end else if (sclk_rise) begin
      bit_cnt_q  <= bit_cnt_q + 3'd1;
      rx_shift_q <= {rx_shift_q[5:0], rx_lvl};
      if (cmd_done) begin
        addr_q <= rx_shift_q;
        rnw_q  <= rx_lvl;
      end else if (byte_done) begin
        addr_q <= next_addr(addr_q);
      end
    end
  end

  // Read data is loaded on the completing rising edge and shifted out on falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift_q <= '0;
      tx         <= 1'b0;
    end else begin
      if (load_en)          tx_shift_q <= rd_byte;
      else if (tx_shift_en) tx_shift_q <= {tx_shift_q[6:0], 1'b0};
      if (tx_shift_en)      tx <= tx_shift_q[7];
      else if (!tx_hold)    tx <= 1'b0;
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (rd_addr)
      ADDR_DEVID_AD:  rd_byte = DEVID_AD;
      ADDR_DEVID_MST: rd_byte = DEVID_MST;
      ADDR_PARTID:    rd_byte = PARTID;
      ADDR_XDATA3:    rd_byte = shadow_q.x[19:12];
      ADDR_XDATA2:    rd_byte = shadow_q.x[11:4];
      ADDR_XDATA1:    rd_byte = {shadow_q.x[3:0], 4'h0};
      ADDR_YDATA3:    rd_byte = shadow_q.y[19:12];
      ADDR_YDATA2:    rd_byte = shadow_q.y[11:4];
      ADDR_YDATA1:    rd_byte = {shadow_q.y[3:0], 4'h0};
      ADDR_ZDATA3:    rd_byte = shadow_q.z[19:12];
      ADDR_ZDATA2:    rd_byte = shadow_q.z[11:4];
      ADDR_ZDATA1:    rd_byte = {shadow_q.z[3:0], 4'h0};
      ADDR_FILTER:    rd_byte = filter;
      ADDR_POWER_CTL: rd_byte = power_ctl;
      default:        rd_byte = 8'h00;
    endcase
  end

  // Register writes; unmapped addresses still report through wr_* outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      power_ctl <= POWER_CTL_RST;
      filter    <= FILTER_RST;
    end else begin
      wr_strobe <= wr_fire;
      if (wr_fire) begin
        wr_addr <= addr_q;
        wr_data <= {rx_shift_q, rx_lvl};
        if (addr_q == ADDR_FILTER)    filter    <= {rx_shift_q, rx_lvl};
        if (addr_q == ADDR_POWER_CTL) power_ctl <= {rx_shift_q, rx_lvl};
      end
    end
  end

  // sample_valid is a single-cycle strobe with no backpressure: it is taken
  // into the shadow directly while deselected, otherwise parked until cs_n rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      if (sample_valid && cs_lvl)       shadow_q <= sample_in;
      else if (cs_rise && pend_valid_q) shadow_q <= pend_q;
      if (sample_valid && !cs_lvl) begin
        pend_q       <= sample_in;
        pend_valid_q <= 1'b1;
      end else if (cs_rise) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

endmodule
